// File: rtl/pipe_pkg.sv
// Shared encodings for the 5-stage RV32 pipeline.
//   PC_SEL_*  : EX next-PC select (anything but PC_SEL_ADD4 is a redirect)
//   WD_SEL_*  : writeback data select (WD_SEL_MEM marks a load)
//   FWD_*     : EX operand forwarding source
//   hz_state_t: hazard controller memory-wait FSM encoding
package pipe_pkg;

    localparam logic [1:0] PC_SEL_ADD4 = 2'd0;
    localparam logic [1:0] PC_SEL_BR   = 2'd1;
    localparam logic [1:0] PC_SEL_JAL  = 2'd2;
    localparam logic [1:0] PC_SEL_JALR = 2'd3;

    localparam logic [1:0] WD_SEL_ALU  = 2'd0;
    localparam logic [1:0] WD_SEL_MEM  = 2'd1;
    localparam logic [1:0] WD_SEL_PC4  = 2'd2;

    localparam logic [1:0] FWD_RF      = 2'd0;
    localparam logic [1:0] FWD_MEM     = 2'd1;
    localparam logic [1:0] FWD_WB      = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } hz_state_t;

    // True when the instruction writes the register file with load data.
    function automatic logic is_load(input logic we, input logic [1:0] wd_sel);
        return we && (wd_sel == WD_SEL_MEM);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX-stage forwarding select for one source operand (purely combinational).
// Ports:
//   ex_rf_ra_i  : EX source register address
//   mem_rf_we_i / mem_rf_wa_i : MEM-stage write enable / destination
//   wb_rf_we_i  / wb_rf_wa_i  : WB-stage write enable / destination
//   fwd_sel_o   : FWD_RF, FWD_MEM or FWD_WB
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] ex_rf_ra_i,
    input  logic       mem_rf_we_i,
    input  logic [4:0] mem_rf_wa_i,
    input  logic       wb_rf_we_i,
    input  logic [4:0] wb_rf_wa_i,
    output logic [1:0] fwd_sel_o
);

    // MEM holds the younger result, so it wins over WB. x0 is never forwarded.
    always_comb begin
        fwd_sel_o = FWD_RF;
        if (mem_rf_we_i && (mem_rf_wa_i != 5'd0) && (mem_rf_wa_i == ex_rf_ra_i)) begin
            fwd_sel_o = FWD_MEM;
        end else if (wb_rf_we_i && (wb_rf_wa_i != 5'd0) && (wb_rf_wa_i == ex_rf_ra_i)) begin
            fwd_sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core.
// Generates stall/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, EX operand
// forwarding selects, and a watchdog on outstanding data-memory accesses.
// Ports:
//   clk_i, rstn_i                 : clock, asynchronous active-low reset
//   id_rf_ra{0,1}_i, id_rf_re{0,1}_i : ID source addresses / read enables
//   ex_rf_ra{0,1}_i               : EX source addresses (forwarding)
//   ex_rf_wa_i, ex_rf_we_i, ex_rf_wd_sel_i : EX destination info (load detection)
//   ex_pc_sel_i                   : EX next-PC select (redirect detection)
//   mem_rf_*_i, wb_rf_*_i         : MEM/WB destination info (forwarding)
//   mem_dm_acc_i, dm_ready_i      : MEM data access handshake
//   stall_*_o, flush_*_o          : per-register hold / bubble controls
//   fwd_sel{0,1}_o                : EX operand forwarding selects
//   mem_timeout_o                 : sticky watchdog error
// Optional build macro HAZARD_PERF_EN adds saturating counters perf_stall_cyc_o,
// perf_loaduse_o and perf_redirect_o (CNT_W bits each).
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [4:0]       id_rf_ra0_i,
    input  logic [4:0]       id_rf_ra1_i,
    input  logic             id_rf_re0_i,
    input  logic             id_rf_re1_i,
    input  logic [4:0]       ex_rf_ra0_i,
    input  logic [4:0]       ex_rf_ra1_i,
    input  logic [4:0]       ex_rf_wa_i,
    input  logic             ex_rf_we_i,
    input  logic [1:0]       ex_rf_wd_sel_i,
    input  logic [1:0]       ex_pc_sel_i,
    input  logic [4:0]       mem_rf_wa_i,
    input  logic             mem_rf_we_i,
    input  logic [4:0]       wb_rf_wa_i,
    input  logic             wb_rf_we_i,
    input  logic             mem_dm_acc_i,
    input  logic             dm_ready_i,
    output logic             stall_pc_o,
    output logic             stall_if_id_o,
    output logic             stall_id_ex_o,
    output logic             stall_ex_mem_o,
    output logic             stall_mem_wb_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             flush_ex_mem_o,
    output logic             flush_mem_wb_o,
    output logic [1:0]       fwd_sel0_o,
    output logic [1:0]       fwd_sel1_o,
    output logic             mem_timeout_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cyc_o,
    output logic [CNT_W-1:0] perf_loaduse_o,
    output logic [CNT_W-1:0] perf_redirect_o
`endif
);

    localparam int unsigned WcW = $clog2(WAIT_MAX + 1);

    if (WAIT_MAX < 1) begin : g_bad_wait_max
        $error("WAIT_MAX must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    hz_state_t          state_q, state_d;
    logic [WcW-1:0]     wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;

    logic               mem_busy;
    logic               redirect;
    logic               load_use;
    logic               redirect_fire;
    logic               load_use_fire;
    logic [1:0]         fwd0, fwd1;

    // ---------------------------------------------------------------- memory-wait FSM
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            IDLE: begin
                if (mem_dm_acc_i && !dm_ready_i) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WcW'(1);
                end
            end
            MEM_WAIT: begin
                if (dm_ready_i) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WcW'(WAIT_MAX)) begin
                    state_d   = TIMEOUT;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WcW'(1);
                end
            end
            TIMEOUT: begin
                // Only reset leaves TIMEOUT.
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Busy uses this cycle's dm_ready, so the very first wait cycle already stalls.
    always_comb begin
        mem_busy = 1'b0;
        case (state_q)
            IDLE:     mem_busy = mem_dm_acc_i && !dm_ready_i;
            MEM_WAIT: mem_busy = !dm_ready_i;
            TIMEOUT:  mem_busy = 1'b1;
            default:  mem_busy = 1'b0;
        endcase
    end

    assign mem_timeout_o = timeout_q;

    // ---------------------------------------------------------------- hazard detection
    assign redirect = (ex_pc_sel_i != PC_SEL_ADD4);
    assign load_use = is_load(ex_rf_we_i, ex_rf_wd_sel_i) && (ex_rf_wa_i != 5'd0) &&
                      ((id_rf_re0_i && (id_rf_ra0_i == ex_rf_wa_i)) ||
                       (id_rf_re1_i && (id_rf_ra1_i == ex_rf_wa_i)));

    // Events actually acted on this cycle after priority resolution.
    assign redirect_fire = rstn_i && !mem_busy && redirect;
    assign load_use_fire = rstn_i && !mem_busy && !redirect && load_use;

    always_comb begin
        stall_pc_o     = 1'b0;
        stall_if_id_o  = 1'b0;
        stall_id_ex_o  = 1'b0;
        stall_ex_mem_o = 1'b0;
        stall_mem_wb_o = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        flush_ex_mem_o = 1'b0;
        flush_mem_wb_o = 1'b0;
        if (!rstn_i) begin
            // Bubbles everywhere while held in reset.
            flush_if_id_o  = 1'b1;
            flush_id_ex_o  = 1'b1;
            flush_ex_mem_o = 1'b1;
            flush_mem_wb_o = 1'b1;
        end else if (mem_busy) begin
            // Freeze everything up to EX/MEM; MEM/WB takes a bubble so WB does not
            // retire the stalled access twice.
            stall_pc_o     = 1'b1;
            stall_if_id_o  = 1'b1;
            stall_id_ex_o  = 1'b1;
            stall_ex_mem_o = 1'b1;
            flush_mem_wb_o = 1'b1;
        end else if (redirect) begin
            flush_if_id_o  = 1'b1;
            flush_id_ex_o  = 1'b1;
        end else if (load_use) begin
            stall_pc_o     = 1'b1;
            stall_if_id_o  = 1'b1;
            flush_id_ex_o  = 1'b1;
        end
    end

    // ---------------------------------------------------------------- forwarding
    fwd_unit u_fwd0 (
        .ex_rf_ra_i  (ex_rf_ra0_i),
        .mem_rf_we_i (mem_rf_we_i),
        .mem_rf_wa_i (mem_rf_wa_i),
        .wb_rf_we_i  (wb_rf_we_i),
        .wb_rf_wa_i  (wb_rf_wa_i),
        .fwd_sel_o   (fwd0)
    );

    fwd_unit u_fwd1 (
        .ex_rf_ra_i  (ex_rf_ra1_i),
        .mem_rf_we_i (mem_rf_we_i),
        .mem_rf_wa_i (mem_rf_wa_i),
        .wb_rf_we_i  (wb_rf_we_i),
        .wb_rf_wa_i  (wb_rf_wa_i),
        .fwd_sel_o   (fwd1)
    );

    assign fwd_sel0_o = rstn_i ? fwd0 : FWD_RF;
    assign fwd_sel1_o = rstn_i ? fwd1 : FWD_RF;

`ifdef HAZARD_PERF_EN
    // ---------------------------------------------------------------- perf counters
    logic [CNT_W-1:0] perf_stall_q, perf_loaduse_q, perf_redirect_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            perf_stall_q    <= '0;
            perf_loaduse_q  <= '0;
            perf_redirect_q <= '0;
        end else begin
            if (stall_pc_o && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + CNT_W'(1);
            end
            if (load_use_fire && (perf_loaduse_q != '1)) begin
                perf_loaduse_q <= perf_loaduse_q + CNT_W'(1);
            end
            if (redirect_fire && (perf_redirect_q != '1)) begin
                perf_redirect_q <= perf_redirect_q + CNT_W'(1);
            end
        end
    end

    assign perf_stall_cyc_o = perf_stall_q;
    assign perf_loaduse_o   = perf_loaduse_q;
    assign perf_redirect_o  = perf_redirect_q;
`else
    logic unused_fire;
    assign unused_fire = redirect_fire ^ load_use_fire;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the control rules.
module tb_hazard_ctrl;

    localparam int unsigned WAIT_MAX = 16;
    localparam int unsigned CNT_W    = 32;

    // Packed control order: {stall pc,ifid,idex,exmem,memwb, flush ifid,idex,exmem,memwb}
    localparam logic [8:0] CtlNone  = 9'b00000_0000;
    localparam logic [8:0] CtlReset = 9'b00000_1111;
    localparam logic [8:0] CtlBusy  = 9'b11110_0001;
    localparam logic [8:0] CtlRedir = 9'b00000_1100;
    localparam logic [8:0] CtlLoad  = 9'b11000_0100;

    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] id_rf_ra0, id_rf_ra1, ex_rf_ra0, ex_rf_ra1, ex_rf_wa, mem_rf_wa, wb_rf_wa;
    logic       id_rf_re0, id_rf_re1, ex_rf_we, mem_rf_we, wb_rf_we, mem_dm_acc, dm_ready;
    logic [1:0] ex_rf_wd_sel, ex_pc_sel;
    logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic       flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
    logic [1:0] fwd_sel0, fwd_sel1;
    logic       mem_timeout;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] perf_stall_cyc, perf_loaduse, perf_redirect;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: in a wait, consecutive ready-low cycles, sticky timeout, counters.
    bit m_wait;
    int m_run;
    bit m_to;
    int m_stall, m_lu, m_redir;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .id_rf_ra0_i    (id_rf_ra0),
        .id_rf_ra1_i    (id_rf_ra1),
        .id_rf_re0_i    (id_rf_re0),
        .id_rf_re1_i    (id_rf_re1),
        .ex_rf_ra0_i    (ex_rf_ra0),
        .ex_rf_ra1_i    (ex_rf_ra1),
        .ex_rf_wa_i     (ex_rf_wa),
        .ex_rf_we_i     (ex_rf_we),
        .ex_rf_wd_sel_i (ex_rf_wd_sel),
        .ex_pc_sel_i    (ex_pc_sel),
        .mem_rf_wa_i    (mem_rf_wa),
        .mem_rf_we_i    (mem_rf_we),
        .wb_rf_wa_i     (wb_rf_wa),
        .wb_rf_we_i     (wb_rf_we),
        .mem_dm_acc_i   (mem_dm_acc),
        .dm_ready_i     (dm_ready),
        .stall_pc_o     (stall_pc),
        .stall_if_id_o  (stall_if_id),
        .stall_id_ex_o  (stall_id_ex),
        .stall_ex_mem_o (stall_ex_mem),
        .stall_mem_wb_o (stall_mem_wb),
        .flush_if_id_o  (flush_if_id),
        .flush_id_ex_o  (flush_id_ex),
        .flush_ex_mem_o (flush_ex_mem),
        .flush_mem_wb_o (flush_mem_wb),
        .fwd_sel0_o     (fwd_sel0),
        .fwd_sel1_o     (fwd_sel1),
        .mem_timeout_o  (mem_timeout)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cyc_o (perf_stall_cyc),
        .perf_loaduse_o   (perf_loaduse),
        .perf_redirect_o  (perf_redirect)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_busy();
        return m_to || (!dm_ready && (m_wait || mem_dm_acc));
    endfunction

    function automatic bit m_loaduse();
        bit hit0 = id_rf_re0 && (id_rf_ra0 == ex_rf_wa);
        bit hit1 = id_rf_re1 && (id_rf_ra1 == ex_rf_wa);
        return ex_rf_we && (ex_rf_wd_sel == 2'd1) && (ex_rf_wa != 0) && (hit0 || hit1);
    endfunction

    function automatic logic [8:0] m_ctl();
        if (!rstn)                return CtlReset;
        if (m_busy())             return CtlBusy;
        if (ex_pc_sel != 2'd0)    return CtlRedir;
        if (m_loaduse())          return CtlLoad;
        return CtlNone;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] ra);
        if (!rstn)                                          return 2'd0;
        if (mem_rf_we && mem_rf_wa != 0 && mem_rf_wa == ra) return 2'd1;
        if (wb_rf_we && wb_rf_wa != 0 && wb_rf_wa == ra)    return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_run = 0; m_to = 0;
        m_stall = 0; m_lu = 0; m_redir = 0;
    endtask

    // One clock cycle: compare outputs mid-cycle, then advance the model at the edge.
    // ectl / efwd1 < 0 means no additional directed expectation.
    task automatic tick(input string tag, input int ectl, input int efwd1);
        logic [8:0] ctl;
        logic [8:0] exp_ctl;
        @(negedge clk);
        #1;
        if (!rstn) model_reset();
        ctl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};
        exp_ctl = m_ctl();
        check_val({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl));
        check_val({tag, ".fwd0"}, 32'(fwd_sel0), 32'(m_fwd(ex_rf_ra0)));
        check_val({tag, ".fwd1"}, 32'(fwd_sel1), 32'(m_fwd(ex_rf_ra1)));
        check_val({tag, ".tmo"}, 32'(mem_timeout), 32'(m_to));
        if (ectl >= 0)  check_val({tag, ".dctl"}, 32'(ctl), 32'(ectl));
        if (efwd1 >= 0) check_val({tag, ".dfwd1"}, 32'(fwd_sel1), 32'(efwd1));
`ifdef HAZARD_PERF_EN
        check_val({tag, ".pstall"}, perf_stall_cyc, 32'(m_stall));
        check_val({tag, ".plu"}, perf_loaduse, 32'(m_lu));
        check_val({tag, ".predir"}, perf_redirect, 32'(m_redir));
`endif
        @(posedge clk);
        if (!rstn) begin
            model_reset();
        end else begin
            if (exp_ctl[8]) m_stall++;
            if (!m_busy() && ex_pc_sel != 2'd0) m_redir++;
            if (!m_busy() && ex_pc_sel == 2'd0 && m_loaduse()) m_lu++;
            if (!m_to) begin
                if (!dm_ready && (m_wait || mem_dm_acc)) begin
                    m_wait = 1;
                    m_run++;
                    if (m_run > int'(WAIT_MAX)) m_to = 1;
                end else if (dm_ready) begin
                    m_wait = 0;
                    m_run  = 0;
                end
            end
        end
        #1;
    endtask

    task automatic quiet();
        id_rf_ra0 = 0; id_rf_ra1 = 0; id_rf_re0 = 0; id_rf_re1 = 0;
        ex_rf_ra0 = 0; ex_rf_ra1 = 0; ex_rf_wa = 0; ex_rf_we = 0; ex_rf_wd_sel = 0;
        ex_pc_sel = 0; mem_rf_wa = 0; mem_rf_we = 0; wb_rf_wa = 0; wb_rf_we = 0;
        mem_dm_acc = 0; dm_ready = 1;
    endtask

    task automatic set_load_use(input logic [4:0] wa);
        ex_rf_we = 1; ex_rf_wd_sel = 2'd1; ex_rf_wa = wa;
        id_rf_ra0 = wa; id_rf_re0 = 1;
    endtask

    initial begin
        int burst = 0;
        model_reset();
        quiet();
        rstn = 0;
        tick("rst0", CtlReset, 0);
        tick("rst1", CtlReset, 0);
        rstn = 1;
        tick("idle", CtlNone, 0);

        // Load-use: one stall cycle, then the bubble removes the hazard.
        set_load_use(5'd5);
        tick("lu", CtlLoad, -1);
        ex_rf_we = 0;
        tick("lu_after", CtlNone, -1);
        set_load_use(5'd0);
        tick("lu_x0", CtlNone, -1);

        // Redirect suppresses a simultaneous load-use.
        set_load_use(5'd9);
        ex_pc_sel = 2'd2;
        tick("redir_lu", CtlRedir, -1);
        quiet();

        // Forwarding priority on operand 1.
        ex_rf_ra1 = 7; mem_rf_wa = 7; wb_rf_wa = 7; mem_rf_we = 1; wb_rf_we = 1;
        tick("fwd_mem", -1, 1);
        mem_rf_we = 0;
        tick("fwd_wb", -1, 2);
        ex_rf_ra1 = 0; mem_rf_wa = 0; wb_rf_wa = 0; mem_rf_we = 1;
        tick("fwd_x0", -1, 0);
        quiet();

        // Three-cycle memory wait with a redirect held back until release.
        mem_dm_acc = 1; dm_ready = 0; ex_pc_sel = 2'd2;
        for (int i = 0; i < 3; i++) tick("mwait", CtlBusy, -1);
        dm_ready = 1; mem_dm_acc = 0;
        tick("mwait_rel", CtlRedir, -1);
        ex_pc_sel = 0;
        tick("mwait_idle", CtlNone, -1);

        // Watchdog.
        mem_dm_acc = 1; dm_ready = 0;
        for (int i = 0; i < int'(WAIT_MAX) + 2; i++) tick("wdog", CtlBusy, -1);
        check_val("wdog.tmo_set", 32'(mem_timeout), 32'd1);
        mem_dm_acc = 0; dm_ready = 1;
        tick("wdog_hold", CtlBusy, -1);
        check_val("wdog.tmo_sticky", 32'(mem_timeout), 32'd1);
        rstn = 0;
        tick("wdog_rst", CtlReset, -1);
        check_val("wdog.tmo_clr", 32'(mem_timeout), 32'd0);
        rstn = 1;

        // Reset pulse in the middle of an ordinary wait.
        mem_dm_acc = 1; dm_ready = 0;
        for (int i = 0; i < 4; i++) tick("wait2", CtlBusy, -1);
        rstn = 0;
        tick("wait2_rst", CtlReset, -1);
        rstn = 1; quiet();
        tick("wait2_idle", CtlNone, -1);

`ifdef HAZARD_PERF_EN
        rstn = 0;
        tick("perf_rst", CtlReset, -1);
        rstn = 1;
        set_load_use(5'd3); tick("perf_lu0", CtlLoad, -1);
        ex_rf_we = 0;       tick("perf_b0", CtlNone, -1);
        set_load_use(5'd4); tick("perf_lu1", CtlLoad, -1);
        quiet();
        ex_pc_sel = 2'd1;   tick("perf_rd", CtlRedir, -1);
        quiet();
        @(negedge clk);
        check_val("perf.loaduse", perf_loaduse, 32'd2);
        check_val("perf.redirect", perf_redirect, 32'd1);
        check_val("perf.stall", perf_stall_cyc, 32'd2);
`endif

        // Randomized traffic with long ready-low bursts and occasional resets.
        for (int c = 0; c < 800; c++) begin
            rstn         = ($urandom_range(0, 69) != 0);
            id_rf_ra0    = 5'($urandom_range(0, 3));
            id_rf_ra1    = 5'($urandom_range(0, 3));
            id_rf_re0    = 1'($urandom);
            id_rf_re1    = 1'($urandom);
            ex_rf_ra0    = 5'($urandom_range(0, 3));
            ex_rf_ra1    = 5'($urandom_range(0, 3));
            ex_rf_wa     = 5'($urandom_range(0, 3));
            ex_rf_we     = 1'($urandom);
            ex_rf_wd_sel = 2'($urandom_range(0, 2));
            ex_pc_sel    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            mem_rf_wa    = 5'($urandom_range(0, 3));
            mem_rf_we    = 1'($urandom);
            wb_rf_wa     = 5'($urandom_range(0, 3));
            wb_rf_we     = 1'($urandom);
            mem_dm_acc   = ($urandom_range(0, 2) == 0);
            if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(5, 22);
            if (burst > 0) begin
                dm_ready = 0;
                burst--;
            end else begin
                dm_ready = ($urandom_range(0, 3) != 0);
            end
            tick("rand", -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
